usb_cdc_echo_fifo: RTL and testbench
====================================

// Module: usb_cdc_echo_fifo
// PURPOSE
//  Byte-stream buffer between the CDC bulk-OUT and bulk-IN ports of usb_cdc.
//  Consumes host->device bytes (usb_cdc out_data_o/out_valid_o/out_ready_i) and
//  returns them, optionally ASCII-upper-cased, to usb_cdc in_data_i/in_valid_i/
//  in_ready_o. Provides an echo/loopback path with backpressure on both sides,
//  gated by the enumeration state.
// PARAMETERS
//  DEPTH        16  FIFO entries; power of two, 2..256
//  SETTLE_CYC   64  consecutive cycles configured_i must be high before RUN
// PORTS
//  clk_i          in   1   single clock, same domain as usb_cdc app clock
//  rst_i          in   1   synchronous reset, active-high
//  configured_i   in   1   usb_cdc configured_o
//  upcase_i       in   1   1: map 'a'..'z' (0x61..0x7A) to 0x41..0x5A on write
//  rx_data_i      in   8   byte from usb_cdc out_data_o
//  rx_valid_i     in   1   usb_cdc out_valid_o
//  rx_ready_o     out  1   to usb_cdc out_ready_i
//  tx_data_o      out  8   to usb_cdc in_data_i
//  tx_valid_o     out  1   to usb_cdc in_valid_i
//  tx_ready_i     in   1   usb_cdc in_ready_o
//  level_o        out  $clog2(DEPTH)+1  current number of stored bytes
//  running_o      out  1   1 while FSM is in RUN
// BEHAVIOUR
//  Reset (rst_i high at clk_i edge): state DISABLED, settle counter 0, read/write
//   pointers 0, level_o 0, rx_ready_o 0, tx_valid_o 0, tx_data_o 8'h00, running_o 0.
//  FSM: DISABLED -> SETTLE when configured_i=1.
//   SETTLE: counter increments each cycle configured_i=1; any cycle with
//   configured_i=0 returns to DISABLED and clears counter; on reaching
//   SETTLE_CYC-1 -> RUN next cycle (counter saturates, never wraps).
//   RUN -> DISABLED on the first cycle configured_i=0; on that same edge the FIFO
//   is flushed (pointers and level to 0); in-flight bytes are discarded.
//  Handshake: transfer occurs on an edge where valid & ready are both 1.
//   rx_ready_o = running_o & (level_o != DEPTH); combinational from registers,
//   no dependence on rx_valid_i. tx_valid_o = running_o & (level_o != 0).
//   tx_data_o is the head entry; stable while tx_valid_o=1 and tx_ready_i=0.
//  Write: accepted byte stored transformed if upcase_i=1 (sampled at accept
//   edge); other values (incl. 0x60, 0x7B, >=0x80) stored unchanged.
//  Latency: byte accepted on edge N is visible with tx_valid_o=1 after edge N
//   (empty FIFO, first-word fall-through via registered head).
//  Simultaneous push and pop: both occur, level_o unchanged. When full, push is
//   impossible (rx_ready_o=0); a pop on that edge re-enables rx_ready_o next cycle.
//  Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; level_o is 0..DEPTH.
//  Outside RUN: rx_ready_o=0, tx_valid_o=0, no pointer movement regardless of
//   valid/ready inputs. rst_i mid-transfer overrides everything (reset values).
//  Byte order preserved strictly FIFO; no byte duplicated or lost while in RUN.
// TESTING
//  1 Reset, configured_i=1 for SETTLE_CYC cycles -> running_o rises exactly
//    SETTLE_CYC cycles after configured_i; glitch low at cycle 30 restarts count.
//  2 RUN, upcase_i=1, push "aZ{`" (61 5A 7B 60), tx_ready_i=1 -> pops 41 5A 7B 60
//    in order; first tx_valid_o one cycle after first accept.
//  3 tx_ready_i=0, push 16 bytes 00..0F -> level_o=16, rx_ready_o=0 on 17th;
//    then tx_ready_i=1 -> bytes 00..0F out, rx_ready_o returns after first pop.
//  4 Level 5, rx_valid_i & tx_ready_i both 1 for 40 cycles -> level_o stays 5,
//    output sequence continuous across pointer wrap (incrementing pattern).
//  5 Level 8, drop configured_i -> next cycle level_o=0, tx_valid_o=0,
//    running_o=0; re-enumerate -> no stale bytes emitted.
//  6 Assert rst_i during streaming -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/usb_cdc_echo_fifo.sv
// Echo buffer between the CDC bulk-OUT and bulk-IN streams: stores received bytes
// (optionally ASCII-upper-cased) and returns them in order once enumeration has settled.
module usb_cdc_echo_fifo #(
  parameter int DEPTH      = 16,
  parameter int SETTLE_CYC = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     configured_i,
  input  logic                     upcase_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_valid_i,
  output logic                     rx_ready_o,
  output logic [7:0]               tx_data_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     running_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(SETTLE_CYC) + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {ST_DISABLED, ST_SETTLE, ST_RUN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            flush;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic            push, pop;

  function automatic logic [7:0] upcase_fn(input logic [7:0] b, input logic en);
    if (en && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

  // The cycle that leaves DISABLED already counts as the first settled cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    flush     = 1'b0;
    case (state)
      ST_DISABLED: begin
        if (configured_i) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = CW'(1);
        end
      end
      ST_SETTLE: begin
        if (!configured_i) begin
          state_nxt = ST_DISABLED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_RUN: begin
        if (!configured_i) begin
          state_nxt = ST_DISABLED;
          cnt_nxt   = '0;
          flush     = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_DISABLED;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign running_o  = (state == ST_RUN);
  assign rx_ready_o = running_o && (level != LVL_FULL);
  assign tx_valid_o = running_o && (level != '0);
  assign tx_data_o  = tx_valid_o ? mem[rd_ptr] : 8'h00;
  assign level_o    = level;
  assign push       = rx_valid_i && rx_ready_o;
  assign pop        = tx_valid_o && tx_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_DISABLED;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
      end
    end
  end

  // Storage carries no reset; pointers and level decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= upcase_fn(rx_data_i, upcase_i);
  end

endmodule

// File: tb/tb_usb_cdc_echo_fifo.sv
// Directed bench for usb_cdc_echo_fifo: settle timing, case mapping, full/empty,
// streaming across pointer wrap, flush on de-configuration and mid-stream reset.
module tb_usb_cdc_echo_fifo;
  localparam int DEPTH  = 16;
  localparam int SETTLE = 64;

  logic       clk = 1'b0;
  logic       rst, configured, upcase, rx_valid, rx_ready, tx_valid, tx_ready, running;
  logic [7:0] rx_data, tx_data;
  logic [4:0] level;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  usb_cdc_echo_fifo #(.DEPTH(DEPTH), .SETTLE_CYC(SETTLE)) dut (
    .clk_i(clk), .rst_i(rst), .configured_i(configured), .upcase_i(upcase),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .level_o(level), .running_o(running)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_run();
    configured = 1'b1;
    repeat (SETTLE) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; configured = 1'b0; upcase = 1'b0; rx_data = 8'h00;
    rx_valid = 1'b0; tx_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h33; tx_ready = 1'b1;
    repeat (2) tick();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%0b exp=0", running); end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready got=%0b exp=0", rx_ready); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%0b exp=0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%0h exp=00", tx_data); end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    rx_valid = 1'b0;
  endtask

  task automatic test_settle();
    configured = 1'b1;
    for (int i = 1; i <= 29; i++) tick();
    configured = 1'b0;
    tick();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL settle_glitch got=%0b exp=0", running); end
    configured = 1'b1;
    for (int i = 1; i < SETTLE; i++) begin
      tick();
      total++; if (running !== 1'b0) begin bad++; $display("FAIL settle_early cyc=%0d got=%0b exp=0", i, running); end
    end
    tick();
    total++; if (running !== 1'b1) begin bad++; $display("FAIL settle_rise got=%0b exp=1", running); end
    repeat (300) tick();
    total++; if (running !== 1'b1) begin bad++; $display("FAIL settle_hold got=%0b exp=1", running); end
  endtask

  task automatic test_upcase();
    logic [7:0] din  [8] = '{8'h61, 8'h5A, 8'h7B, 8'h60, 8'h7A, 8'h40, 8'hE1, 8'h61};
    logic       up   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] dexp [8] = '{8'h41, 8'h5A, 8'h7B, 8'h60, 8'h5A, 8'h40, 8'hE1, 8'h61};
    tx_ready = 1'b1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL upcase_idle got=%0b exp=0", tx_valid); end
    for (int i = 0; i < 8; i++) begin
      rx_data = din[i]; upcase = up[i]; rx_valid = 1'b1;
      total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL upcase_ready i=%0d got=%0b exp=1", i, rx_ready); end
      tick();
      total++; if (tx_valid !== 1'b1 || tx_data !== dexp[i]) begin
        bad++; $display("FAIL upcase_data i=%0d got=%0b/%0h exp=1/%0h", i, tx_valid, tx_data, dexp[i]); end
      total++; if (level !== 5'd1) begin bad++; $display("FAIL upcase_level i=%0d got=%0d exp=1", i, level); end
    end
    rx_valid = 1'b0; upcase = 1'b0;
    tick();
    total++; if (tx_valid !== 1'b0 || level !== 5'd0) begin
      bad++; $display("FAIL upcase_drain got=%0b/%0d exp=0/0", tx_valid, level); end
  endtask

  task automatic test_full();
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rx_data = 8'(i); rx_valid = 1'b1;
      total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL full_ready i=%0d got=%0b exp=1", i, rx_ready); end
      tick();
    end
    total++; if (level !== 5'd16) begin bad++; $display("FAIL full_level got=%0d exp=16", level); end
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL full_ready17 got=%0b exp=0", rx_ready); end
    rx_data = 8'h10;
    tick();
    total++; if (level !== 5'd16 || tx_data !== 8'h00) begin
      bad++; $display("FAIL full_hold got=%0d/%0h exp=16/00", level, tx_data); end
    rx_valid = 1'b0; tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
        bad++; $display("FAIL full_pop i=%0d got=%0b/%0h exp=1/%0h", i, tx_valid, tx_data, 8'(i)); end
      tick();
      if (i == 0) begin
        total++; if (rx_ready !== 1'b1 || level !== 5'd15) begin
          bad++; $display("FAIL full_reenable got=%0b/%0d exp=1/15", rx_ready, level); end
      end
    end
    total++; if (tx_valid !== 1'b0 || level !== 5'd0) begin
      bad++; $display("FAIL full_empty got=%0b/%0d exp=0/0", tx_valid, level); end
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b0; rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin rx_data = 8'(i); tick(); end
    total++; if (level !== 5'd5) begin bad++; $display("FAIL b2b_prefill got=%0d exp=5", level); end
    tx_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rx_data = 8'(i + 5);
      total++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
        bad++; $display("FAIL b2b_data i=%0d got=%0b/%0h exp=1/%0h", i, tx_valid, tx_data, 8'(i)); end
      tick();
      total++; if (level !== 5'd5) begin bad++; $display("FAIL b2b_level i=%0d got=%0d exp=5", i, level); end
    end
    rx_valid = 1'b0;
    for (int i = 40; i < 45; i++) begin
      total++; if (tx_data !== 8'(i)) begin bad++; $display("FAIL b2b_tail i=%0d got=%0h exp=%0h", i, tx_data, 8'(i)); end
      tick();
    end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL b2b_empty got=%0d exp=0", level); end
  endtask

  task automatic test_flush();
    tx_ready = 1'b0; rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin rx_data = 8'hA0 + 8'(i); tick(); end
    total++; if (level !== 5'd8) begin bad++; $display("FAIL flush_fill got=%0d exp=8", level); end
    configured = 1'b0; tx_ready = 1'b1; rx_data = 8'hEE;
    tick();
    total++; if (level !== 5'd0) begin bad++; $display("FAIL flush_level got=%0d exp=0", level); end
    total++; if (tx_valid !== 1'b0 || running !== 1'b0 || rx_ready !== 1'b0) begin
      bad++; $display("FAIL flush_ctrl got=%0b%0b%0b exp=000", tx_valid, running, rx_ready); end
    tick();
    total++; if (level !== 5'd0) begin bad++; $display("FAIL flush_idle got=%0d exp=0", level); end
    rx_valid = 1'b0;
    enter_run();
    total++; if (running !== 1'b1 || tx_valid !== 1'b0 || level !== 5'd0) begin
      bad++; $display("FAIL flush_rerun got=%0b/%0b/%0d exp=1/0/0", running, tx_valid, level); end
    tx_ready = 1'b0; rx_valid = 1'b1; rx_data = 8'h55;
    tick();
    rx_valid = 1'b0;
    total++; if (tx_data !== 8'h55 || level !== 5'd1) begin
      bad++; $display("FAIL flush_fresh got=%0h/%0d exp=55/1", tx_data, level); end
  endtask

  task automatic test_reset_mid();
    rx_valid = 1'b1; tx_ready = 1'b1; rx_data = 8'h77;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    total++; if (running !== 1'b0 || rx_ready !== 1'b0 || tx_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_ctrl got=%0b%0b%0b exp=000", running, rx_ready, tx_valid); end
    total++; if (tx_data !== 8'h00 || level !== 5'd0) begin
      bad++; $display("FAIL rstmid_data got=%0h/%0d exp=00/0", tx_data, level); end
    rst = 1'b0; rx_valid = 1'b0;
    tick();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL rstmid_after got=%0b exp=0", running); end
  endtask

  initial begin
    test_reset();
    test_settle();
    test_upcase();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
